rvfi_coverage_collector: RTL and testbench

RVFI_COVERAGE_COLLECTOR -- requirements
Module: rvfi_coverage_collector

---
 rtl/rvfi_coverage_pkg.sv | 18 +
 rtl/rvfi_coverage_fifo.sv | 47 ++++
 rtl/rvfi_coverage_collector.sv | 199 +++++++++++++++++++
 tb/tb_rvfi_coverage_collector.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_coverage_pkg.sv
// Shared types and helpers for the RVFI coverage collector.
// The counter saturation helper works on a 32-bit carrier so any CNT_W up to 32 can use it.
package rvfi_coverage_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int unsigned INSN_W = 32;

   function automatic logic [31:0] satInc(input logic [31:0] value, input int unsigned width);
      logic [31:0] maxVal;
      maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= maxVal) ? maxVal : value + 32'd1;
   endfunction

endpackage

// File: rtl/rvfi_coverage_fifo.sv
// Per-channel retire FIFO: synchronous, power-of-two depth, flush clears it.
// A push while full is accepted only when a pop happens in the same cycle.
module rvfi_coverage_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wrPtr_q;
   logic [PTR_W:0]   rdPtr_q;
   logic             doPush;
   logic             doPop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                    (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);
   assign data_o  = mem_q[rdPtr_q[PTR_W-1:0]];

   always_ff @(posedge clock) begin
      if (flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (doPush && !flush_i) mem_q[wrPtr_q[PTR_W-1:0]] <= data_i;
   end

endmodule

// File: rtl/rvfi_coverage_collector.sv
// RVFI coverage collector: per-channel FIFOs feed one shared decoder through a round-robin arbiter.
// Define RVFI_COVERAGE_ONEHOT_CHECK_EN to reject multi-bit decoder hits and expose multi_hit.
module rvfi_coverage_collector
   import rvfi_coverage_pkg::*;
#(
   parameter int unsigned NRET       = 2,
   parameter int unsigned NINSN      = 64,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NRET-1:0]          rvfi_valid,
   input  logic [NRET*INSN_W-1:0]   rvfi_insn,
   output logic [INSN_W-1:0]        dec_insn,
   input  logic [NINSN-1:0]         dec_hit,
   input  logic                     clear,
   input  logic                     rd_req,
   input  logic [$clog2(NINSN)-1:0] rd_idx,
   output logic                     rd_ack,
   output logic [CNT_W-1:0]         rd_count,
   output logic                     busy,
   output logic                     overflow,
   output logic                     unknown
`ifdef RVFI_COVERAGE_ONEHOT_CHECK_EN
   ,
   output logic                     multi_hit
`endif
);

   localparam int unsigned IDX_W = $clog2(NINSN);
   localparam int unsigned GNT_W = (NRET > 1) ? $clog2(NRET) : 1;

   state_e             state_q;
   logic [IDX_W-1:0]   sweepIdx_q;
   logic [GNT_W-1:0]   lastGrant_q;
   logic               overflow_q;
   logic               unknown_q;
   logic               rdAck_q;
   logic [CNT_W-1:0]   rdCount_q;
   logic [CNT_W-1:0]   cnt_q [NINSN];

   logic               running;
   logic               flush;
   logic [NRET-1:0]    fifoFull;
   logic [NRET-1:0]    fifoEmpty;
   logic [NRET-1:0]    fifoPush;
   logic [NRET-1:0]    fifoPop;
   logic [INSN_W-1:0]  fifoHead [NRET];

   logic               grantValid;
   logic [GNT_W-1:0]   grantIdx;
   int                 arbCand;
   logic [IDX_W-1:0]   hitIdx;
   logic               hitFound;
   logic               multiHit;
   int                 hitCount;
   logic               incEn;
   logic               dropAny;

   assign running = (state_q == RUN) && !reset;
   assign flush   = reset || clear;

   for (genvar ch = 0; ch < NRET; ch++) begin : gChan
      assign fifoPush[ch] = running && rvfi_valid[ch];
      assign fifoPop[ch]  = grantValid && (grantIdx == GNT_W'(ch));

      rvfi_coverage_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (INSN_W)
      ) uFifo (
         .clock   (clock),
         .flush_i (flush),
         .push_i  (fifoPush[ch]),
         .data_i  (rvfi_insn[ch*INSN_W +: INSN_W]),
         .pop_i   (fifoPop[ch]),
         .data_o  (fifoHead[ch]),
         .full_o  (fifoFull[ch]),
         .empty_o (fifoEmpty[ch])
      );
   end

   // Search starts one past the last winner so every busy channel is served in turn.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      arbCand    = 0;
      for (int i = 1; i <= int'(NRET); i++) begin
         arbCand = (int'(lastGrant_q) + i) % int'(NRET);
         if (running && !grantValid && !fifoEmpty[GNT_W'(arbCand)]) begin
            grantValid = 1'b1;
            grantIdx   = GNT_W'(arbCand);
         end
      end
   end

   assign dec_insn = grantValid ? fifoHead[grantIdx] : '0;

   always_comb begin
      hitIdx   = '0;
      hitFound = 1'b0;
      hitCount = 0;
      for (int i = 0; i < int'(NINSN); i++) begin
         if (dec_hit[i]) begin
            if (!hitFound) begin
               hitIdx   = IDX_W'(i);
               hitFound = 1'b1;
            end
            hitCount = hitCount + 1;
         end
      end
`ifdef RVFI_COVERAGE_ONEHOT_CHECK_EN
      multiHit = (hitCount > 1);
`else
      multiHit = 1'b0;
`endif
      incEn = grantValid && hitFound && !multiHit;
   end

   assign dropAny = running && |(rvfi_valid & fifoFull & ~fifoPop);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= CLEAR;
         sweepIdx_q  <= '0;
         lastGrant_q <= GNT_W'(NRET - 1);
         overflow_q  <= 1'b0;
         unknown_q   <= 1'b0;
      end else begin
         if (grantValid) lastGrant_q <= grantIdx;
         if (dropAny) overflow_q <= 1'b1;
         if (grantValid && (dec_hit == '0)) unknown_q <= 1'b1;
         case (state_q)
            CLEAR: begin
               if (clear) begin
                  sweepIdx_q <= '0;
               end else if (sweepIdx_q == IDX_W'(NINSN - 1)) begin
                  state_q <= RUN;
               end else begin
                  sweepIdx_q <= sweepIdx_q + 1'b1;
               end
            end
            RUN: begin
               if (clear) begin
                  state_q    <= CLEAR;
                  sweepIdx_q <= '0;
               end
            end
            default: state_q <= CLEAR;
         endcase
      end
   end

`ifdef RVFI_COVERAGE_ONEHOT_CHECK_EN
   logic multiHit_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         multiHit_q <= 1'b0;
      end else if (grantValid && multiHit) begin
         multiHit_q <= 1'b1;
      end
   end

   assign multi_hit = multiHit_q;
`endif

   // Counters are not reset directly; the CLEAR sweep that follows reset zeroes them.
   always_ff @(posedge clock) begin
      for (int i = 0; i < int'(NINSN); i++) begin
         if (state_q == CLEAR) begin
            if (sweepIdx_q == IDX_W'(i)) cnt_q[i] <= '0;
         end else if (incEn && (hitIdx == IDX_W'(i))) begin
            cnt_q[i] <= CNT_W'(satInc(32'(cnt_q[i]), CNT_W));
         end
      end
   end

   // Read data is sampled before this cycle's counter update lands.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdAck_q   <= 1'b0;
         rdCount_q <= '0;
      end else begin
         rdAck_q <= rd_req;
         if (rd_req) begin
            if ((state_q == CLEAR) || (32'(rd_idx) >= NINSN)) rdCount_q <= '0;
            else rdCount_q <= cnt_q[rd_idx];
         end
      end
   end

   assign rd_ack   = rdAck_q;
   assign rd_count = rdCount_q;
   assign busy     = (state_q == CLEAR);
   assign overflow = overflow_q;
   assign unknown  = unknown_q;

endmodule

// File: tb/tb_rvfi_coverage_collector.sv
// Directed and randomized bench for rvfi_coverage_collector (NRET=2, NINSN=64, CNT_W=4).
// A queue-based reference model predicts grants, counters, reads and sticky flags each cycle.
module tb_rvfi_coverage_collector;

   logic        clock;
   logic        reset;
   logic [1:0]  rvfi_valid;
   logic [63:0] rvfi_insn;
   logic [31:0] dec_insn;
   logic [63:0] dec_hit;
   logic        clear;
   logic        rd_req;
   logic [5:0]  rd_idx;
   logic        rd_ack;
   logic [3:0]  rd_count;
   logic        busy;
   logic        overflow;
   logic        unknown;
`ifdef RVFI_COVERAGE_ONEHOT_CHECK_EN
   logic        multi_hit;
`endif

   int nCompared = 0;
   int nMismatch = 0;

   bit          mRun;
   int          mSweep;
   logic [31:0] mQ0 [$];
   logic [31:0] mQ1 [$];
   int          mLast;
   int          mCnt [64];
   bit          mOvf;
   bit          mUnk;
   bit          mMulti;
   bit          mAck;
   int          mRdVal;
   int          mGrant [2];
   int          obsGrant [2];
   int          mGrantTotal;

   rvfi_coverage_collector #(
      .NRET       (2),
      .NINSN      (64),
      .CNT_W      (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rvfi_valid (rvfi_valid),
      .rvfi_insn  (rvfi_insn),
      .dec_insn   (dec_insn),
      .dec_hit    (dec_hit),
      .clear      (clear),
      .rd_req     (rd_req),
      .rd_idx     (rd_idx),
      .rd_ack     (rd_ack),
      .rd_count   (rd_count),
      .busy       (busy),
      .overflow   (overflow),
      .unknown    (unknown)
`ifdef RVFI_COVERAGE_ONEHOT_CHECK_EN
      ,
      .multi_hit  (multi_hit)
`endif
   );

   // Stand-in for the external decoder: bit31 -> no hit, bit30 -> bits 1 and 2, else one-hot at [25:20].
   function automatic logic [63:0] decodeInsn(input logic [31:0] insn);
      if (insn[31]) return 64'd0;
      if (insn[30]) return 64'h6;
      return 64'd1 << insn[25:20];
   endfunction

   assign dec_hit = decodeInsn(dec_insn);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatch++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] randInsn(input int ch, input int lo, input int hi);
      logic [31:0] insn;
      insn        = $urandom;
      insn[31:30] = 2'b00;
      insn[29]    = ch[0];
      insn[25:20] = 6'($urandom_range(hi, lo));
      return insn;
   endfunction

   // One clock: check the combinational grant, advance the model at the edge, check registered outputs.
   task automatic stepCycle();
      int          g;
      int          li;
      logic [31:0] expInsn;
      logic [63:0] hit;
      g       = -1;
      li      = -1;
      expInsn = '0;
      #1;
      if (!reset && mRun) begin
         for (int i = 1; i <= 2; i++) begin
            int c;
            c = (mLast + i) % 2;
            if (g < 0 && ((c == 0) ? mQ0.size() : mQ1.size()) > 0) g = c;
         end
         if (g == 0) expInsn = mQ0[0];
         else if (g == 1) expInsn = mQ1[0];
      end
      checkOutput("dec_insn", 64'(dec_insn), 64'(expInsn));
      if (dec_insn != 32'd0) obsGrant[int'(dec_insn[29])]++;
      @(posedge clock);
      if (reset) begin
         mRun = 0; mSweep = 0; mLast = 1; mAck = 0; mRdVal = 0;
         mOvf = 0; mUnk = 0; mMulti = 0; mGrantTotal = 0;
         mQ0.delete(); mQ1.delete();
      end else begin
         mAck = rd_req;
         if (rd_req) mRdVal = mRun ? mCnt[rd_idx] : 0;
         if (!mRun) begin
            mCnt[mSweep] = 0;
            if (clear) mSweep = 0;
            else if (mSweep == 63) mRun = 1;
            else mSweep++;
         end else begin
            if (g >= 0) begin
               if (g == 0) mQ0.delete(0); else mQ1.delete(0);
               mLast = g;
               mGrant[g]++;
               mGrantTotal++;
               hit = decodeInsn(expInsn);
               if (hit == 64'd0) mUnk = 1;
`ifdef RVFI_COVERAGE_ONEHOT_CHECK_EN
               else if ($countones(hit) > 1) mMulti = 1;
`endif
               else begin
                  for (int b = 0; b < 64; b++) if (li < 0 && hit[b]) li = b;
                  mCnt[li] = (mCnt[li] >= 15) ? 15 : mCnt[li] + 1;
               end
            end
            if (rvfi_valid[0]) begin
               if (mQ0.size() < 4) mQ0.push_back(rvfi_insn[31:0]); else mOvf = 1;
            end
            if (rvfi_valid[1]) begin
               if (mQ1.size() < 4) mQ1.push_back(rvfi_insn[63:32]); else mOvf = 1;
            end
            if (clear) begin
               mRun = 0; mSweep = 0; mGrantTotal = 0;
               mQ0.delete(); mQ1.delete();
            end
         end
      end
      #1;
      checkOutput("busy", 64'(busy), 64'(!mRun));
      checkOutput("overflow", 64'(overflow), 64'(mOvf));
      checkOutput("unknown", 64'(unknown), 64'(mUnk));
      checkOutput("rd_ack", 64'(rd_ack), 64'(mAck));
      if (mAck) checkOutput("rd_count", 64'(rd_count), 64'(mRdVal));
`ifdef RVFI_COVERAGE_ONEHOT_CHECK_EN
      checkOutput("multi_hit", 64'(multi_hit), 64'(mMulti));
`endif
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                                input logic rq, input logic [5:0] ri, input logic clr);
      rvfi_valid = v;
      rvfi_insn  = {i1, i0};
      rd_req     = rq;
      rd_idx     = ri;
      clear      = clr;
      stepCycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(2'b00, '0, '0, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic readCounter(input logic [5:0] idx);
      applyStimulus(2'b00, '0, '0, 1'b1, idx, 1'b0);
   endtask

   task automatic waitSweep(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         idle(1);
         n++;
      end
      checkOutput(tag, 64'(n), 64'd64);
   endtask

   initial begin
      int sum;
      logic [31:0] r0;
      logic [31:0] r1;
      for (int i = 0; i < 64; i++) mCnt[i] = 0;
      mGrant[0] = 0; mGrant[1] = 0; obsGrant[0] = 0; obsGrant[1] = 0;
      mRun = 0; mSweep = 0; mLast = 1; mOvf = 0; mUnk = 0; mMulti = 0; mAck = 0; mRdVal = 0;

      reset = 1'b1;
      idle(3);
      checkOutput("reset_busy", 64'(busy), 64'd1);
      checkOutput("reset_rd_ack", 64'(rd_ack), 64'd0);
      checkOutput("reset_rd_count", 64'(rd_count), 64'd0);
      checkOutput("reset_dec_insn", 64'(dec_insn), 64'd0);
      reset = 1'b0;
      waitSweep("sweep_after_reset");
      readCounter(6'd5);
      checkOutput("idx5_after_reset", 64'(rd_count), 64'd0);

      $display("[TB] two channels retire ADDI together");
      applyStimulus(2'b11, 32'h0030_0093, 32'h0030_0113, 1'b0, 6'd0, 1'b0);
      checkOutput("grant_first_ch0", 64'(dec_insn), 64'h0030_0093);
      idle(1);
      checkOutput("grant_second_ch1", 64'(dec_insn), 64'h0030_0113);
      idle(2);
      readCounter(6'd3);
      checkOutput("addi_count_idx3", 64'(rd_count), 64'd2);

      $display("[TB] both channels retire every cycle");
      mGrant[0] = 0; mGrant[1] = 0; obsGrant[0] = 0; obsGrant[1] = 0;
      for (int i = 0; i < 10; i++)
         applyStimulus(2'b11, randInsn(0, 8, 63), randInsn(1, 8, 63), 1'b0, 6'd0, 1'b0);
      idle(12);
      checkOutput("overflow_set", 64'(overflow), 64'd1);
      checkOutput("ch0_grants", 64'(obsGrant[0]), 64'(mGrant[0]));
      checkOutput("ch1_grants", 64'(obsGrant[1]), 64'(mGrant[1]));
      sum = 0;
      for (int i = 0; i < 64; i++) begin
         readCounter(6'(i));
         sum += int'(rd_count);
      end
      checkOutput("count_total", 64'(sum), 64'(mGrantTotal));

      $display("[TB] saturation on idx 7");
      for (int i = 0; i < 20; i++) applyStimulus(2'b01, 32'h0070_0000, '0, 1'b0, 6'd0, 1'b0);
      idle(3);
      readCounter(6'd7);
      checkOutput("saturate_idx7", 64'(rd_count), 64'd15);

      $display("[TB] clear, read during sweep, restart");
      applyStimulus(2'b11, 32'h0070_0000, 32'h0070_0000, 1'b0, 6'd0, 1'b1);
      checkOutput("clear_busy", 64'(busy), 64'd1);
      idle(10);
      readCounter(6'd7);
      checkOutput("read_in_clear", 64'(rd_count), 64'd0);
      applyStimulus(2'b00, '0, '0, 1'b0, 6'd0, 1'b1);
      waitSweep("sweep_after_restart");

      $display("[TB] read colliding with increment");
      for (int i = 0; i < 4; i++) applyStimulus(2'b01, 32'h0030_0093, '0, 1'b0, 6'd0, 1'b0);
      idle(3);
      applyStimulus(2'b01, 32'h0030_0093, '0, 1'b0, 6'd0, 1'b0);
      applyStimulus(2'b00, '0, '0, 1'b1, 6'd3, 1'b0);
      checkOutput("collide_ack", 64'(rd_ack), 64'd1);
      checkOutput("collide_pre_value", 64'(rd_count), 64'd4);
      readCounter(6'd3);
      checkOutput("collide_post_value", 64'(rd_count), 64'd5);

      $display("[TB] unknown and multi-bit decoder responses");
      applyStimulus(2'b01, 32'h8050_0000, '0, 1'b0, 6'd0, 1'b0);
      idle(2);
      checkOutput("unknown_set", 64'(unknown), 64'd1);
      applyStimulus(2'b01, 32'h4000_0000, '0, 1'b0, 6'd0, 1'b0);
      idle(2);
`ifdef RVFI_COVERAGE_ONEHOT_CHECK_EN
      checkOutput("multi_hit_set", 64'(multi_hit), 64'd1);
`endif
      for (int i = 0; i < 64; i++) readCounter(6'(i));

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         r0 = randInsn(0, 0, 63);
         r1 = randInsn(1, 0, 63);
         if ($urandom_range(0, 15) == 0) r0[31] = 1'b1;
         if ($urandom_range(0, 15) == 0) r1[30] = 1'b1;
         applyStimulus(2'($urandom), r0, r1, 1'($urandom), 6'($urandom),
                       ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end
      idle(80);
      for (int i = 0; i < 64; i++) readCounter(6'(i));

      $display("[TB] reset during sweep with a read pending");
      applyStimulus(2'b00, '0, '0, 1'b0, 6'd0, 1'b1);
      idle(5);
      reset = 1'b1;
      applyStimulus(2'b00, '0, '0, 1'b1, 6'd5, 1'b0);
      checkOutput("reset_suppresses_ack", 64'(rd_ack), 64'd0);
      checkOutput("reset_clears_overflow", 64'(overflow), 64'd0);
      reset = 1'b0;
      waitSweep("sweep_after_midreset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
